rw_arbiter: RTL and testbench

RW_ARBITER -- requirements
Module: rw_arbiter

---
 rtl/rw_arbiter_pkg.sv | 31 +++
 rtl/rw_arbiter_grant.sv | 37 +++
 rtl/rw_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_rw_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rw_arbiter_pkg.sv
// rw_arbiter_pkg: shared types and constants for the I/D-cache to memory arbiter.
// Holds the transaction FSM states, the port identity, and the tag field layout.
package rw_arbiter_pkg;

  // Transaction FSM: one outstanding transaction at a time.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_WDONE = 3'd3,
    ST_RDATA = 3'd4
  } state_t;

  // Requesting cache port.
  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  // Tag layout: [12] read/write, [11:8] transaction type, [7:0] id.
  localparam int TAG_RW_BIT   = 12;
  localparam int TAG_TYPE_MSB = 11;
  localparam int TAG_TYPE_LSB = 8;
  localparam int TAG_ID_MSB   = 7;
  localparam int TAG_ID_LSB   = 0;

  localparam logic       TAG_READ    = 1'b1;
  localparam logic       TAG_WRITE   = 1'b0;
  localparam logic [3:0] TYPE_MEMORY = 4'b0001;

endpackage

// File: rtl/rw_arbiter_grant.sv
// rw_arbiter_grant: picks which cache port wins the bus when leaving IDLE.
// Build option ARB_ROUND_ROBIN_EN: simultaneous requests alternate against
// last_grant. Without it the D-cache always wins a tie.
module rw_arbiter_grant
  import rw_arbiter_pkg::*;
(
  input  logic  i_reqcyc,
  input  logic  d_reqcyc,
  input  port_t last_grant,
  output port_t grant
);

`ifdef ARB_ROUND_ROBIN_EN
  // Tie goes to the port that did not win last time; a lone request wins.
  always_comb begin
    grant = PORT_D;
    if (i_reqcyc && d_reqcyc) begin
      grant = (last_grant == PORT_D) ? PORT_I : PORT_D;
    end else if (i_reqcyc) begin
      grant = PORT_I;
    end
  end
`else
  // Fixed priority has no use for the grant history.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // D-cache has fixed priority; I-cache wins only when D is silent.
  always_comb begin
    grant = PORT_D;
    if (i_reqcyc && !d_reqcyc) begin
      grant = PORT_I;
    end
  end
`endif

endmodule

// File: rtl/rw_arbiter.sv
// rw_arbiter: shares one memory bus between an I-cache and a D-cache port.
// A transaction is an address beat followed either by BEATS write-data beats
// (closed by a one-cycle writeack) or by BEATS read-response beats.
// Build option ARB_ROUND_ROBIN_EN selects round-robin tie breaking in
// rw_arbiter_grant; the default build gives the D-cache priority.
module rw_arbiter
  import rw_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13,
  parameter int BEATS      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  // I-cache port
  input  logic [DATA_WIDTH-1:0] i_req,
  input  logic [TAG_WIDTH-1:0]  i_reqtag,
  input  logic                  i_reqcyc,
  output logic                  i_reqack,
  output logic [DATA_WIDTH-1:0] i_resp,
  output logic [TAG_WIDTH-1:0]  i_resptag,
  output logic                  i_respcyc,
  input  logic                  i_respack,
  output logic                  i_writeack,
  // D-cache port
  input  logic [DATA_WIDTH-1:0] d_req,
  input  logic [TAG_WIDTH-1:0]  d_reqtag,
  input  logic                  d_reqcyc,
  output logic                  d_reqack,
  output logic [DATA_WIDTH-1:0] d_resp,
  output logic [TAG_WIDTH-1:0]  d_resptag,
  output logic                  d_respcyc,
  input  logic                  d_respack,
  output logic                  d_writeack,
  // Memory bus
  output logic [DATA_WIDTH-1:0] bus_req,
  output logic [TAG_WIDTH-1:0]  bus_reqtag,
  output logic                  bus_reqcyc,
  input  logic                  bus_reqack,
  input  logic [DATA_WIDTH-1:0] bus_resp,
  input  logic [TAG_WIDTH-1:0]  bus_resptag,
  input  logic                  bus_respcyc,
  output logic                  bus_respack
);

  localparam int                CNT_W     = $clog2(BEATS);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  state_t           state, state_nx;
  port_t            owner, owner_nx;
  port_t            last_grant, last_grant_nx;
  port_t            grant;
  logic [CNT_W-1:0] cnt, cnt_nx;

  // Owner-side view of the transaction, demuxed to the ports below.
  logic own_reqack;
  logic own_respcyc;
  logic own_writeack;

  // Selected owner's request signals.
  logic                  own_reqcyc;
  logic [DATA_WIDTH-1:0] own_req;
  logic [TAG_WIDTH-1:0]  own_reqtag;
  logic                  own_respack;
  logic                  in_rdata;

  assign own_reqcyc  = (owner == PORT_D) ? d_reqcyc  : i_reqcyc;
  assign own_req     = (owner == PORT_D) ? d_req     : i_req;
  assign own_reqtag  = (owner == PORT_D) ? d_reqtag  : i_reqtag;
  assign own_respack = (owner == PORT_D) ? d_respack : i_respack;
  assign in_rdata    = (state == ST_RDATA);

  rw_arbiter_grant u_grant (
    .i_reqcyc   (i_reqcyc),
    .d_reqcyc   (d_reqcyc),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // State, owner, grant history and beat counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      owner      <= PORT_I;
      last_grant <= PORT_D;
      cnt        <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_grant <= last_grant_nx;
      cnt        <= cnt_nx;
    end
  end

  // Next-state logic and owner-side handshakes for the current phase.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_grant_nx = last_grant;
    cnt_nx        = cnt;
    bus_req       = '0;
    bus_reqtag    = '0;
    bus_reqcyc    = 1'b0;
    bus_respack   = 1'b0;
    own_reqack    = 1'b0;
    own_respcyc   = 1'b0;
    own_writeack  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_reqcyc || d_reqcyc) begin
          owner_nx      = grant;
          last_grant_nx = grant;
          state_nx      = ST_ADDR;
        end
      end

      ST_ADDR: begin
        bus_req    = own_req;
        bus_reqtag = own_reqtag;
        bus_reqcyc = own_reqcyc;
        own_reqack = bus_reqack && own_reqcyc;
        if (!own_reqcyc) begin
          // Owner withdrew before the bus accepted the address.
          state_nx = ST_IDLE;
        end else if (bus_reqack) begin
          cnt_nx   = '0;
          state_nx = (own_reqtag[TAG_RW_BIT] == TAG_READ) ? ST_RDATA : ST_WDATA;
        end
      end

      ST_WDATA: begin
        bus_req    = own_req;
        bus_reqtag = own_reqtag;
        bus_reqcyc = own_reqcyc;
        own_reqack = bus_reqack && own_reqcyc;
        if (own_reqack) begin
          if (cnt == LAST_BEAT) begin
            cnt_nx   = '0;
            state_nx = ST_WDONE;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end

      ST_WDONE: begin
        own_writeack = 1'b1;
        state_nx     = ST_IDLE;
      end

      ST_RDATA: begin
        own_respcyc = bus_respcyc;
        bus_respack = own_respack;
        if (bus_respcyc && own_respack) begin
          if (cnt == LAST_BEAT) begin
            cnt_nx   = '0;
            state_nx = ST_IDLE;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

  // Only the owner ever sees handshakes; the other port stays quiet.
  assign i_reqack   = own_reqack   && (owner == PORT_I);
  assign d_reqack   = own_reqack   && (owner == PORT_D);
  assign i_respcyc  = own_respcyc  && (owner == PORT_I);
  assign d_respcyc  = own_respcyc  && (owner == PORT_D);
  assign i_writeack = own_writeack && (owner == PORT_I);
  assign d_writeack = own_writeack && (owner == PORT_D);

  // Response data is only passed through to the owner while reading.
  assign i_resp    = (in_rdata && owner == PORT_I) ? bus_resp    : '0;
  assign i_resptag = (in_rdata && owner == PORT_I) ? bus_resptag : '0;
  assign d_resp    = (in_rdata && owner == PORT_D) ? bus_resp    : '0;
  assign d_resptag = (in_rdata && owner == PORT_D) ? bus_resptag : '0;

endmodule

// File: tb/tb_rw_arbiter.sv
// tb_rw_arbiter: self-checking bench for rw_arbiter. The bench plays both
// caches and the memory; a transaction-level model tracks who should own the
// bus, which word each side must see, and when writeack is due.
module tb_rw_arbiter;
  localparam int DW    = 64;
  localparam int TW    = 13;
  localparam int BEATS = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] i_req, d_req, i_resp, d_resp, bus_req, bus_resp;
  logic [TW-1:0] i_reqtag, d_reqtag, i_resptag, d_resptag, bus_reqtag, bus_resptag;
  logic          i_reqcyc, d_reqcyc, i_reqack, d_reqack, i_respcyc, d_respcyc;
  logic          i_respack, d_respack, i_writeack, d_writeack;
  logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;

  always #5 clk = ~clk;

  rw_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_reqtag(i_reqtag), .i_reqcyc(i_reqcyc), .i_reqack(i_reqack),
    .i_resp(i_resp), .i_resptag(i_resptag), .i_respcyc(i_respcyc),
    .i_respack(i_respack), .i_writeack(i_writeack),
    .d_req(d_req), .d_reqtag(d_reqtag), .d_reqcyc(d_reqcyc), .d_reqack(d_reqack),
    .d_resp(d_resp), .d_resptag(d_resptag), .d_respcyc(d_respcyc),
    .d_respack(d_respack), .d_writeack(d_writeack),
    .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqcyc(bus_reqcyc),
    .bus_reqack(bus_reqack), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .bus_respcyc(bus_respcyc), .bus_respack(bus_respack)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Transaction-level model; port index 0 = I-cache, 1 = D-cache.
  bit            pend[2];
  bit            is_rd[2];
  logic [TW-1:0] tagv[2];
  logic [DW-1:0] addrv[2];
  int            wptr[2];
  int            rptr[2];
  int            nack[2];
  int            nwack[2];
  int            own;
  bit            lg;          // 1 when D received the most recent grant
  bit            rdata_ph;
  bit            wack_due;
  // Memory responder
  bit            mem_rd;
  bit            mvalid;
  int            mbeat;
  logic [DW-1:0] maddr;
  logic [TW-1:0] mtag;
  // Run control
  int            mode;        // 0 random, 1 quiet, 2 quiet + beat-4 stall on I
  int            stall_left;
  int            grants[$];
  int            cyc;
  int            first_bus;

  function automatic logic [DW-1:0] word(input int p, input int k);
    return (k == 0) ? addrv[p] : ((addrv[p] ^ 64'hDA7A_0000_0000_0000) + 64'(k));
  endfunction

  function automatic int need(input int p);
    return is_rd[p] ? 1 : BEATS + 1;
  endfunction

  function automatic int arb(input bit ireq, input bit dreq);
    if (ireq && dreq) begin
`ifdef ARB_ROUND_ROBIN_EN
      return lg ? 0 : 1;
`else
      return 1;
`endif
    end
    return dreq ? 1 : 0;
  endfunction

  // Drive all bench-side inputs for the coming cycle.
  task automatic drive();
    bit quiet;
    quiet     = (mode != 0);
    i_reqcyc  = pend[0] && (wptr[0] < need(0));
    d_reqcyc  = pend[1] && (wptr[1] < need(1));
    i_req     = word(0, wptr[0]);
    d_req     = word(1, wptr[1]);
    i_reqtag  = tagv[0];
    d_reqtag  = tagv[1];
    i_respack = quiet ? 1'b1 : ($urandom_range(0, 2) != 0);
    d_respack = quiet ? 1'b1 : ($urandom_range(0, 2) != 0);
    if (mode == 2 && own == 0 && rdata_ph && rptr[0] == 4 && stall_left > 0) begin
      i_respack = 1'b0;
      stall_left--;
    end
    bus_reqack = quiet ? 1'b1 : ($urandom_range(0, 1) == 1);
    if (mem_rd) begin
      if (!mvalid) mvalid = quiet || ($urandom_range(0, 1) == 1);
      bus_respcyc = mvalid;
      bus_resp    = maddr + 64'(mbeat);
      bus_resptag = mtag;
    end else begin
      bus_respcyc = !quiet && ($urandom_range(0, 3) == 0);
      bus_resp    = {$urandom, $urandom};
      bus_resptag = TW'($urandom);
    end
  endtask

  // Compare DUT outputs against the model at the falling edge and advance it.
  task automatic evaluate();
    bit         ph_r, ph_wack, acked, oack;
    int         o;
    logic [1:0] exp_vec;
    ph_r    = rdata_ph;
    ph_wack = wack_due;
    if (bus_reqcyc && first_bus < 0) first_bus = cyc;

    exp_vec = ph_wack ? ((own == 1) ? 2'b10 : 2'b01) : 2'b00;
    check("writeack", {d_writeack, i_writeack}, exp_vec);
    nwack[0] += int'(i_writeack);
    nwack[1] += int'(d_writeack);
    if (ph_r || ph_wack) check("bus_reqcyc_quiet", bus_reqcyc, 1'b0);

    acked = bus_reqcyc && bus_reqack;
    if (acked && own < 0) begin
      own = arb(i_reqcyc, d_reqcyc);
      lg  = (own == 1);
      grants.push_back(own);
    end
    exp_vec = acked ? ((own == 1) ? 2'b10 : 2'b01) : 2'b00;
    check("reqack", {d_reqack, i_reqack}, exp_vec);
    if (acked) begin
      check("bus_req", bus_req, word(own, wptr[own]));
      check("bus_reqtag", bus_reqtag, tagv[own]);
      nack[own]++;
      wptr[own]++;
      if (wptr[own] == 1 && is_rd[own]) begin
        rdata_ph = 1'b1;
        mem_rd   = 1'b1;
        mvalid   = 1'b0;
        mbeat    = 0;
        maddr    = bus_req;
        mtag     = bus_reqtag;
      end else if (wptr[own] == BEATS + 1) begin
        wack_due = 1'b1;
      end
    end

    o       = own;
    oack    = (o == 1) ? d_respack : i_respack;
    exp_vec = (ph_r && bus_respcyc) ? ((o == 1) ? 2'b10 : 2'b01) : 2'b00;
    check("respcyc", {d_respcyc, i_respcyc}, exp_vec);
    check("bus_respack", bus_respack, ph_r ? oack : 1'b0);
    if (mode == 2 && ph_r && o == 0 && rptr[0] == 4 && !i_respack) begin
      check("stall_beat", i_resp, addrv[0] + 64'd4);
      check("stall_cyc", i_respcyc, 1'b1);
    end
    if (ph_r && bus_respcyc && oack) begin
      check("resp", (o == 1) ? d_resp : i_resp, addrv[o] + 64'(rptr[o]));
      check("resptag", (o == 1) ? d_resptag : i_resptag, tagv[o]);
      rptr[o]++;
      mbeat++;
      mvalid = 1'b0;
      if (rptr[o] == BEATS) begin
        rdata_ph = 1'b0;
        mem_rd   = 1'b0;
        pend[o]  = 1'b0;
        own      = -1;
      end
    end

    if (ph_wack) begin
      wack_due = 1'b0;
      if (own >= 0) pend[own] = 1'b0;
      own = -1;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, {i_reqack, d_reqack, i_respcyc, d_respcyc, i_writeack,
                          d_writeack, bus_reqcyc, bus_respack}, 8'h00);
    check({tag, "_bus_req"}, bus_req, '0);
    check({tag, "_tags"}, {bus_reqtag, i_resptag, d_resptag}, '0);
    check({tag, "_i_resp"}, i_resp, '0);
    check({tag, "_d_resp"}, d_resp, '0);
  endtask

  // One round: launch up to one transaction per port in the same cycle and
  // run until both finish. abort_d > 0 stops after that many D acks.
  task automatic run_round(input bit ui, input bit ud, input bit ri, input bit rd,
                           input logic [DW-1:0] ai, input logic [DW-1:0] ad,
                           input int md, input int abort_d);
    bit done;
    @(posedge clk);
    #1;
    mode       = md;
    stall_left = 3;
    pend[0]    = ui;
    pend[1]    = ud;
    is_rd[0]   = ri;
    is_rd[1]   = rd;
    addrv[0]   = ai;
    addrv[1]   = ad;
    tagv[0]    = {ri, 4'b0001, ai[7:0]};
    tagv[1]    = {rd, 4'b0001, ad[7:0]};
    for (int p = 0; p < 2; p++) begin
      wptr[p] = 0; rptr[p] = 0; nack[p] = 0; nwack[p] = 0;
    end
    grants.delete();
    cyc       = 0;
    first_bus = -1;
    done      = 1'b0;
    drive();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      evaluate();
      if (abort_d > 0 && nack[1] == abort_d) return;
      if (!pend[0] && !pend[1]) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
      drive();
    end
    if (!done) begin
      check("round_timeout", 64'd0, 64'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
    check("bus_latency", 64'(first_bus), 64'd1);
    check("i_ack_count", 64'(nack[0]), ui ? 64'(need(0)) : 64'd0);
    check("d_ack_count", 64'(nack[1]), ud ? 64'(need(1)) : 64'd0);
    check("i_wack_count", 64'(nwack[0]), (ui && !ri) ? 64'd1 : 64'd0);
    check("d_wack_count", 64'(nwack[1]), (ud && !rd) ? 64'd1 : 64'd0);
  endtask

  task automatic clear_model();
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; is_rd[p] = 1'b0; tagv[p] = '0; addrv[p] = '0;
      wptr[p] = 0; rptr[p] = 0;
    end
    own      = -1;
    lg       = 1'b1;
    rdata_ph = 1'b0;
    wack_due = 1'b0;
    mem_rd   = 1'b0;
    mvalid   = 1'b0;
    mbeat    = 0;
  endtask

  initial begin
    clear_model();
    mode  = 1;
    reset = 1'b0;
    drive();
    // Busy inputs during reset must not leak through.
    i_reqcyc    = 1'b1;
    d_reqcyc    = 1'b1;
    bus_respcyc = 1'b1;
    bus_resp    = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    drive();
    @(negedge clk);
    reset = 1'b1;

    // I-cache read alone; memory returns 0x10..0x17.
    run_round(1'b1, 1'b0, 1'b1, 1'b0, 64'h10, 64'h0, 1, 0);

    // Simultaneous I/D requests, twice: D is served first, then I.
    for (int r = 0; r < 2; r++) begin
      run_round(1'b1, 1'b1, 1'b1, 1'b0, 64'h100 + 64'(r), 64'h500 + 64'(r), 1, 0);
      check("tie_first_grant", 64'(grants[0]), 64'd1);
      check("tie_second_grant", 64'(grants[1]), 64'd0);
    end

    // D write with tag 0x0100: address plus eight data beats.
    run_round(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h2000, 1, 0);
    check("d_write_tag", 64'(tagv[1]), 64'h0100);

    // I read with the consumer stalling three cycles on beat 4.
    run_round(1'b1, 1'b0, 1'b1, 1'b0, 64'h40, 64'h0, 2, 0);

    // Reset during WDATA beat 5 of a D write.
    run_round(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h3000, 1, 6);
    #2;
    reset = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    clear_model();
    drive();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_reset_wack", {d_writeack, i_writeack}, 2'b00);
      check("post_reset_bus", bus_reqcyc, 1'b0);
    end

    // Randomized rounds with random handshake timing and stray responses.
    for (int r = 0; r < 40; r++) begin
      bit ui, ud;
      ui = ($urandom_range(0, 1) == 1);
      ud = ($urandom_range(0, 1) == 1);
      if (!ui && !ud) ud = 1'b1;
      run_round(ui, ud, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                {$urandom, $urandom}, {$urandom, $urandom}, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
